sdram_port_arbiter: RTL

- Shares one Avalon-MM SDRAM port (FPGA-to-HPS SDRAM bridge) between two masters:
  - frame reader (read-only, port "rd");
  - frame writer (write-only, port "wr").
- Grant is locked for a whole command: one accepted read command, or a full write burst.
- Arbitration is round-robin, with an urgency override for the reader so the pixel FIFO does not underrun.
- Sits between the reader/writer blocks and the sdram_* top-level Avalon signals.

---
 rtl/sdram_pkg.sv | 28 ++
 rtl/sdram_port_arbiter_chk.sv | 24 ++
 rtl/sdram_port_arbiter_pending_tracker.sv | 42 ++++
 rtl/sdram_port_arbiter.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/sdram_pkg.sv
// Shared types and defaults for the SDRAM port arbiter slice.
package sdram_pkg;

  localparam int SDRAM_DATA_WIDTH_DEF = 64;
  localparam int ADDR_WIDTH_DEF       = 29;
  localparam logic [28:0] BUFFER0_AVALON_ADDR = 29'h0400_0000;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_GRANT = 2'd1,
    WR_GRANT = 2'd2
  } arb_state_t;

  typedef enum logic {
    GRANT_RD = 1'b0,
    GRANT_WR = 1'b1
  } grant_t;

  // A zero burstcount is illegal and handled as a single beat.
  function automatic logic [16:0] burst_beats(input logic [15:0] bc);
    if (bc == 16'd0) begin
      return 17'd1;
    end else begin
      return {1'b0, bc};
    end
  endfunction

endpackage

// File: rtl/sdram_port_arbiter_chk.sv
// Simulation checks for illegal burst lengths and read-return underflow.
module sdram_port_arbiter_chk #(
  parameter int BURST_WIDTH = 8
) (
  input logic                   clk,
  input logic                   rst,
  input logic                   rd_accept,
  input logic [BURST_WIDTH-1:0] rd_burstcount,
  input logic                   wr_first_accept,
  input logic [BURST_WIDTH-1:0] wr_burstcount,
  input logic                   rd_beat_valid,
  input logic [16:0]            pending
);

  a_rd_burst_nonzero: assert property (@(posedge clk) disable iff (rst)
    rd_accept |-> (rd_burstcount != '0));

  a_wr_burst_nonzero: assert property (@(posedge clk) disable iff (rst)
    wr_first_accept |-> (wr_burstcount != '0));

  a_no_return_underflow: assert property (@(posedge clk) disable iff (rst)
    (rd_beat_valid && !rd_accept) |-> (pending != 17'd0));

endmodule

// File: rtl/sdram_port_arbiter_pending_tracker.sv
// Outstanding read-beat counter and the reader's capacity check.
module arb_pending_tracker
  import sdram_pkg::*;
#(
  parameter int BURST_WIDTH = 8,
  parameter int MAX_PENDING = 256
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [BURST_WIDTH-1:0] rd_burstcount,
  input  logic                   rd_accept,
  input  logic                   rd_beat_valid,
  output logic                   rd_room,
  output logic [16:0]            pending
);

  logic [16:0] beats;
  logic [16:0] pending_next;

  assign beats   = burst_beats(16'(rd_burstcount));
  assign rd_room = ({1'b0, pending} + {1'b0, beats}) <= 18'(MAX_PENDING);

  // Accept and return in the same cycle both apply; underflow saturates at zero.
  always_comb begin
    pending_next = pending;
    case ({rd_accept, rd_beat_valid})
      2'b10:   pending_next = pending + beats;
      2'b01:   pending_next = (pending == 17'd0) ? 17'd0 : pending - 17'd1;
      2'b11:   pending_next = pending + beats - 17'd1;
      default: pending_next = pending;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= 17'd0;
    end else begin
      pending <= pending_next;
    end
  end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Two-master (reader/writer) arbiter for one Avalon-MM SDRAM port.
// Optional performance counters are enabled with `define ARB_PERF_CNT_EN.
module sdram_port_arbiter
  import sdram_pkg::*;
#(
  parameter int SDRAM_DATA_WIDTH = SDRAM_DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH       = ADDR_WIDTH_DEF,
  parameter int BURST_WIDTH      = 8,
  parameter int MAX_PENDING      = 256
) (
  input  logic                          sdram_clk,
  input  logic                          rst,
  input  logic [ADDR_WIDTH-1:0]         rd_address_i,
  input  logic [BURST_WIDTH-1:0]        rd_burstcount_i,
  input  logic                          rd_read_i,
  input  logic                          rd_urgent_i,
  output logic                          rd_waitrequest_o,
  output logic [SDRAM_DATA_WIDTH-1:0]   rd_readdata_o,
  output logic                          rd_readdatavalid_o,
  input  logic [ADDR_WIDTH-1:0]         wr_address_i,
  input  logic [BURST_WIDTH-1:0]        wr_burstcount_i,
  input  logic                          wr_write_i,
  input  logic [SDRAM_DATA_WIDTH-1:0]   wr_writedata_i,
  input  logic [SDRAM_DATA_WIDTH/8-1:0] wr_byteenable_i,
  output logic                          wr_waitrequest_o,
  output logic [ADDR_WIDTH-1:0]         sdram_address_o,
  output logic [BURST_WIDTH-1:0]        sdram_burstcount_o,
  output logic                          sdram_read_o,
  output logic                          sdram_write_o,
  output logic [SDRAM_DATA_WIDTH-1:0]   sdram_writedata_o,
  output logic [SDRAM_DATA_WIDTH/8-1:0] sdram_byteenable_o,
  input  logic                          sdram_waitrequest_i,
  input  logic [SDRAM_DATA_WIDTH-1:0]   sdram_readdata_i,
  input  logic                          sdram_readdatavalid_i,
  output logic [31:0]                   rd_grant_cnt_o,
  output logic [31:0]                   wr_grant_cnt_o,
  output logic [31:0]                   stall_cnt_o
);

  arb_state_t           state, state_next;
  grant_t               last_grant;
  logic                 rd_room, rd_elig, wr_elig;
  logic                 rd_accept, wr_accept, wr_last;
  logic [16:0]          pending;
  logic [BURST_WIDTH:0] wr_beat, wr_len, wr_first_len, wr_cur_len;

  assign rd_readdata_o      = sdram_readdata_i;
  assign rd_readdatavalid_o = sdram_readdatavalid_i;

  assign rd_elig   = rd_read_i & rd_room;
  assign wr_elig   = wr_write_i;
  assign rd_accept = (state == RD_GRANT) & rd_read_i & ~sdram_waitrequest_i;
  assign wr_accept = (state == WR_GRANT) & wr_write_i & ~sdram_waitrequest_i;

  // Burst length comes from the first beat; later beats use the latched copy.
  assign wr_first_len = (wr_burstcount_i == '0) ? {{BURST_WIDTH{1'b0}}, 1'b1}
                                                : {1'b0, wr_burstcount_i};
  assign wr_cur_len   = (wr_beat == '0) ? wr_first_len : wr_len;
  assign wr_last      = ((wr_beat + {{BURST_WIDTH{1'b0}}, 1'b1}) == wr_cur_len);

  arb_pending_tracker #(
    .BURST_WIDTH (BURST_WIDTH),
    .MAX_PENDING (MAX_PENDING)
  ) u_pending (
    .clk           (sdram_clk),
    .rst           (rst),
    .rd_burstcount (rd_burstcount_i),
    .rd_accept     (rd_accept),
    .rd_beat_valid (sdram_readdatavalid_i),
    .rd_room       (rd_room),
    .pending       (pending)
  );

  sdram_port_arbiter_chk #(.BURST_WIDTH(BURST_WIDTH)) u_chk (
    .clk             (sdram_clk),
    .rst             (rst),
    .rd_accept       (rd_accept),
    .rd_burstcount   (rd_burstcount_i),
    .wr_first_accept (wr_accept && (wr_beat == '0)),
    .wr_burstcount   (wr_burstcount_i),
    .rd_beat_valid   (sdram_readdatavalid_i),
    .pending         (pending)
  );

  always_ff @(posedge sdram_clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= GRANT_WR;
      wr_beat    <= '0;
      wr_len     <= '0;
    end else begin
      state <= state_next;
      if (state == IDLE && state_next == RD_GRANT) begin
        last_grant <= GRANT_RD;
      end else if (state == IDLE && state_next == WR_GRANT) begin
        last_grant <= GRANT_WR;
      end
      if (wr_accept) begin
        if (wr_beat == '0) begin
          wr_len <= wr_first_len;
        end
        wr_beat <= wr_last ? '0 : wr_beat + {{BURST_WIDTH{1'b0}}, 1'b1};
      end
    end
  end

  // Urgency beats fairness; otherwise the master not served last wins a tie.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (rd_elig && (rd_urgent_i || !wr_elig || last_grant == GRANT_WR)) begin
          state_next = RD_GRANT;
        end else if (wr_elig) begin
          state_next = WR_GRANT;
        end else begin
          state_next = IDLE;
        end
      end
      RD_GRANT: begin
        if (!rd_read_i || !sdram_waitrequest_i) begin
          state_next = IDLE;
        end else begin
          state_next = RD_GRANT;
        end
      end
      WR_GRANT: begin
        if (wr_accept && wr_last) begin
          state_next = IDLE;
        end else begin
          state_next = WR_GRANT;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    sdram_read_o       = 1'b0;
    sdram_write_o      = 1'b0;
    sdram_address_o    = rd_address_i;
    sdram_burstcount_o = rd_burstcount_i;
    sdram_writedata_o  = wr_writedata_i;
    sdram_byteenable_o = wr_byteenable_i;
    rd_waitrequest_o   = 1'b1;
    wr_waitrequest_o   = 1'b1;
    case (state)
      RD_GRANT: begin
        sdram_read_o     = rd_read_i;
        rd_waitrequest_o = sdram_waitrequest_i;
      end
      WR_GRANT: begin
        sdram_write_o      = wr_write_i;
        sdram_address_o    = wr_address_i;
        sdram_burstcount_o = wr_burstcount_i;
        wr_waitrequest_o   = sdram_waitrequest_i;
      end
      default: begin
        sdram_read_o = 1'b0;
      end
    endcase
  end

`ifdef ARB_PERF_CNT_EN
  logic [31:0] rd_grant_cnt, wr_grant_cnt, stall_cnt;

  always_ff @(posedge sdram_clk) begin
    if (rst) begin
      rd_grant_cnt <= 32'd0;
      wr_grant_cnt <= 32'd0;
      stall_cnt    <= 32'd0;
    end else begin
      if (rd_accept) begin
        rd_grant_cnt <= rd_grant_cnt + 32'd1;
      end
      if (wr_accept && wr_last) begin
        wr_grant_cnt <= wr_grant_cnt + 32'd1;
      end
      if ((sdram_read_o || sdram_write_o) && sdram_waitrequest_i) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
    end
  end

  assign rd_grant_cnt_o = rd_grant_cnt;
  assign wr_grant_cnt_o = wr_grant_cnt;
  assign stall_cnt_o    = stall_cnt;
`else
  assign rd_grant_cnt_o = 32'd0;
  assign wr_grant_cnt_o = 32'd0;
  assign stall_cnt_o    = 32'd0;
`endif

endmodule
